// File: rtl/adder_input_gather_if.sv
// ============================================================================
//  Module   : adder_input_gather_if
//  Brief    : Word-stream input and packed-group output handshake bundle for
//             the adder input gatherer.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface adder_input_gather_if #(
    parameter int BITS = 16,
    parameter int NUM  = 4
);
    logic                in_valid;
    logic [BITS-1:0]     in_data;
    logic                in_last;
    logic                in_ready;
    logic [NUM*BITS-1:0] out_data;
    logic                out_valid;
    logic                out_ready;

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_data, out_valid
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_data, out_valid
    );
endinterface

`default_nettype wire

// File: rtl/adder_input_gather.sv
// ============================================================================
//  Module   : adder_input_gather
//  Brief    : Packs NUM consecutive BITS-wide words into one registered group
//             for the adder tree. Define ADDER_GATHER_PAD_EN to let in_last
//             close a group early with zero padding.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module adder_input_gather #(
    parameter int BITS = 16,
    parameter int NUM  = 4
) (
    input  wire logic            clk,
    input  wire logic            reset,
    adder_input_gather_if.slave  bus
);
    localparam int            CW     = (NUM > 1) ? $clog2(NUM) : 1;
    localparam logic [CW-1:0] C_LAST = CW'(NUM - 1);

    logic [CW-1:0]       cnt_q, cnt_d;
    logic [NUM*BITS-1:0] collect_q, collect_d;
    logic [NUM*BITS-1:0] out_data_q, out_data_d;
    logic                out_valid_q, out_valid_d;

    logic                w_accept;
    logic                w_last_slot;
    logic                w_complete;
    logic                w_in_ready;
    logic [NUM*BITS-1:0] w_group;

    assign w_last_slot = (cnt_q == C_LAST);
    assign w_accept    = bus.in_valid && w_in_ready;

`ifdef ADDER_GATHER_PAD_EN
    // An early in_last could complete at any slot, so only a free output may accept.
    assign w_in_ready = !out_valid_q || bus.out_ready;
    assign w_complete = w_accept && (w_last_slot || bus.in_last);
`else
    assign w_in_ready = !(out_valid_q && !bus.out_ready && w_last_slot);
    assign w_complete = w_accept && w_last_slot;

    logic w_unused_last;
    assign w_unused_last = bus.in_last;
`endif

    // Slots above cnt are already zero, so this is also the zero-padded group.
    always_comb begin
        w_group                        = collect_q;
        w_group[cnt_q * BITS +: BITS]  = bus.in_data;
    end

    always_comb begin
        cnt_d       = cnt_q;
        collect_d   = collect_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;

        if (w_accept) begin
            if (w_complete) begin
                cnt_d     = '0;
                collect_d = '0;
            end else begin
                cnt_d     = cnt_q + CW'(1);
                collect_d = w_group;
            end
        end

        if (w_complete) begin
            out_data_d  = w_group;
            out_valid_d = 1'b1;
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q       <= '0;
            collect_q   <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            collect_q   <= collect_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid_q;

endmodule

`default_nettype wire

// File: tb/tb_adder_input_gather.sv
// ============================================================================
//  Module   : tb_adder_input_gather
//  Brief    : Self-checking bench for adder_input_gather, NUM=4 and NUM=3
//             instances driven in parallel against a word-list reference model.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_adder_input_gather;
`ifdef ADDER_GATHER_PAD_EN
    localparam bit PAD = 1'b1;
`else
    localparam bit PAD = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    adder_input_gather_if #(.BITS(16), .NUM(4)) bus4 ();
    adder_input_gather_if #(.BITS(16), .NUM(3)) bus3 ();

    adder_input_gather #(.BITS(16), .NUM(4)) u_dut4 (.clk(clk), .reset(reset), .bus(bus4));
    adder_input_gather #(.BITS(16), .NUM(3)) u_dut3 (.clk(clk), .reset(reset), .bus(bus3));

    int tests = 0;
    int fails = 0;

    // Reference model: list of words waiting for a group, plus the presented group.
    int          nm [2] = '{4, 3};
    logic [15:0] pend [2][4];
    int          pcnt [2];
    int          words [2];
    logic        last_acc [2];
    logic        m_valid [2];
    logic [63:0] m_data [2];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic dut_ready(input int d);
        return (d == 0) ? bus4.in_ready : bus3.in_ready;
    endfunction

    function automatic logic dut_valid(input int d);
        return (d == 0) ? bus4.out_valid : bus3.out_valid;
    endfunction

    function automatic logic [63:0] dut_data(input int d);
        return (d == 0) ? bus4.out_data : {16'h0000, bus3.out_data};
    endfunction

    function automatic logic model_ready(input int d, input logic ordy);
        if (PAD) return !m_valid[d] || ordy;
        return !(m_valid[d] && !ordy && (pcnt[d] == nm[d] - 1));
    endfunction

    function automatic void model_reset();
        for (int d = 0; d < 2; d++) begin
            pcnt[d]    = 0;
            m_valid[d] = 1'b0;
            m_data[d]  = '0;
        end
    endfunction

    function automatic void mstep(input int d, input logic v, input logic [15:0] data,
                                  input logic last, input logic ordy, input logic rdy);
        logic acc, done;
        acc  = v && rdy;
        done = 1'b0;
        if (acc) begin
            pend[d][pcnt[d]] = data;
            pcnt[d]++;
            words[d]++;
            done = (pcnt[d] == nm[d]) || (PAD && last);
        end
        last_acc[d] = acc;
        if (done) begin
            m_data[d] = '0;
            for (int k = 0; k < pcnt[d]; k++) m_data[d][k*16 +: 16] = pend[d][k];
            pcnt[d]    = 0;
            m_valid[d] = 1'b1;
        end else if (ordy) begin
            m_valid[d] = 1'b0;
        end
    endfunction

    task automatic drive(input logic v, input logic [15:0] data, input logic last, input logic ordy);
        bus4.in_valid = v;  bus4.in_data = data;  bus4.in_last = last;  bus4.out_ready = ordy;
        bus3.in_valid = v;  bus3.in_data = data;  bus3.in_last = last;  bus3.out_ready = ordy;
    endtask

    task automatic cycle(input logic v, input logic [15:0] data, input logic last, input logic ordy);
        logic rdy [2];
        drive(v, data, last, ordy);
        #1;
        for (int d = 0; d < 2; d++) begin
            rdy[d] = model_ready(d, ordy);
            chk($sformatf("in_ready_n%0d", nm[d]), {63'b0, dut_ready(d)}, {63'b0, rdy[d]});
        end
        @(posedge clk);
        for (int d = 0; d < 2; d++) mstep(d, v, data, last, ordy, rdy[d]);
        #1;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("out_valid_n%0d", nm[d]), {63'b0, dut_valid(d)}, {63'b0, m_valid[d]});
            chk($sformatf("out_data_n%0d", nm[d]), dut_data(d), m_data[d]);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive(1'b0, 16'h0000, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        #1;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("rst_valid_n%0d", nm[d]), {63'b0, dut_valid(d)}, 64'd0);
            chk($sformatf("rst_data_n%0d", nm[d]), dut_data(d), 64'd0);
            chk($sformatf("rst_ready_n%0d", nm[d]), {63'b0, dut_ready(d)}, 64'd1);
        end
    endtask

    initial begin
        int k;
        int cyc;
        words[0] = 0;
        words[1] = 0;
        reset = 1'b1;
        drive(1'b0, 16'h0000, 1'b0, 1'b0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;

        // Step 1: reset values, then a gap-free stream 1..8 with out_ready high.
        do_reset();
        for (int w = 1; w <= 8; w++) begin
            cycle(1'b1, 16'(w), 1'b0, 1'b1);
            if (w == 4) begin
                chk("grp1_data", bus4.out_data, 64'h0004_0003_0002_0001);
                chk("grp1_valid", {63'b0, bus4.out_valid}, 64'd1);
            end
            if (w == 5) chk("grp1_pulse_end", {63'b0, bus4.out_valid}, 64'd0);
            if (w == 8) begin
                chk("grp2_data", bus4.out_data, 64'h0008_0007_0006_0005);
                chk("grp2_valid", {63'b0, bus4.out_valid}, 64'd1);
            end
        end

        // Step 2: stall with out_ready low, then release; words re-presented until taken.
        do_reset();
        k = 0;
        for (int c = 0; c < 8; c++) begin
            cycle(1'b1, 16'h0021 + 16'(k), 1'b0, 1'b0);
            if (last_acc[0]) k++;
        end
        chk("stall_ready", {63'b0, bus4.in_ready}, 64'd0);
        chk("stall_hold", bus4.out_data, 64'h0024_0023_0022_0021);
        cyc = 0;
        while (k < 8 && cyc < 20) begin
            cycle(1'b1, 16'h0021 + 16'(k), 1'b0, 1'b1);
            if (last_acc[0]) begin
                k++;
                if (k == 8) chk("stall_grp2", bus4.out_data, 64'h0028_0027_0026_0025);
            end
            cyc++;
        end
        chk("stall_budget", {63'b0, (k == 8)}, 64'd1);
        cycle(1'b0, 16'h0000, 1'b0, 1'b1);

        // Step 3: in_last on the second word.
        do_reset();
        cycle(1'b1, 16'h0010, 1'b0, 1'b1);
        cycle(1'b1, 16'h0020, 1'b1, 1'b1);
        if (PAD) begin
            chk("pad_data", bus4.out_data, 64'h0000_0000_0020_0010);
            chk("pad_valid", {63'b0, bus4.out_valid}, 64'd1);
        end else begin
            chk("nopad_valid", {63'b0, bus4.out_valid}, 64'd0);
        end
        cycle(1'b1, 16'h0030, 1'b0, 1'b1);
        cycle(1'b1, 16'h0040, 1'b0, 1'b1);
        if (PAD) begin
            chk("pad_next_valid", {63'b0, bus4.out_valid}, 64'd0);
            cycle(1'b1, 16'h0050, 1'b0, 1'b1);
            cycle(1'b1, 16'h0060, 1'b0, 1'b1);
            chk("pad_next_data", bus4.out_data, 64'h0060_0050_0040_0030);
        end else begin
            chk("nopad_data", bus4.out_data, 64'h0040_0030_0020_0010);
            chk("nopad_valid2", {63'b0, bus4.out_valid}, 64'd1);
        end

        // Step 4: reset mid-group and with a pending output.
        do_reset();
        cycle(1'b1, 16'h00B1, 1'b0, 1'b1);
        cycle(1'b1, 16'h00B2, 1'b0, 1'b1);
        do_reset();
        for (int w = 0; w < 4; w++) cycle(1'b1, 16'h00C1 + 16'(w), 1'b0, 1'b0);
        chk("pend_valid", {63'b0, bus4.out_valid}, 64'd1);
        do_reset();
        for (int w = 0; w < 4; w++) cycle(1'b1, 16'h00A1 + 16'(w), 1'b0, 1'b1);
        chk("post_rst_data", bus4.out_data, 64'h00A4_00A3_00A2_00A1);
        chk("post_rst_valid", {63'b0, bus4.out_valid}, 64'd1);
        cycle(1'b0, 16'h0000, 1'b0, 1'b1);
        chk("post_rst_once", {63'b0, bus4.out_valid}, 64'd0);

        // Step 5: random gaps and backpressure for 10k words on the NUM=4 instance.
        do_reset();
        words[0] = 0;
        cyc = 0;
        while (words[0] < 10000 && cyc < 40000) begin
            cycle(($urandom_range(0, 3) != 0), 16'($urandom), ($urandom_range(0, 7) == 0),
                  ($urandom_range(0, 3) != 0));
            cyc++;
        end
        chk("rand_budget", {63'b0, (words[0] >= 10000)}, 64'd1);
        repeat (4) cycle(1'b0, 16'h0000, 1'b0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

`default_nettype wire
